// File: rtl/t_utils_pkg.sv
// Shared constants and helpers for the four-way buffered demultiplexer.
package t_utils_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  // One-hot decode of a channel select; an unknown select enables no channel.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    case (sel)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with a full flag for a single output channel.
// A load in the same cycle as a take wins, so the slot reloads and stays full.
module demux_slot #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] data_in,
  input  logic             take,
  output logic             valid,
  output logic [width-1:0] data_out
);

  // Full flag and payload register; data holds its last value when not loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (take) begin
      valid    <= 1'b0;
      data_out <= data_out;
    end else begin
      valid    <= valid;
      data_out <= data_out;
    end
  end

endmodule

// File: rtl/demux4_buf.sv
// Four-way buffered demultiplexer: steers one valid/ready stream into four
// one-entry channel slots chosen per beat by in_sel. Backpressure is per
// channel, so a stalled consumer only blocks beats addressed to it.
// Optional feature macro: DEMUX4_CNT_EN adds per-channel 16-bit accepted-beat
// counters on out_cnt.
module demux4_buf
  import t_utils_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [width-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*width-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready
`ifdef DEMUX4_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] out_cnt
`endif
);

  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] avail_s;
  logic [NUM_CH-1:0] load_s;

  // A slot can take a beat when empty or when its current beat drains this cycle.
  assign avail_s   = ~full_s | out_ready;
  assign out_valid = full_s;

  // 4:1 select of the addressed channel's availability.
  always_comb begin
    in_ready = 1'b0;
    case (in_sel)
      2'd0:    in_ready = avail_s[0];
      2'd1:    in_ready = avail_s[1];
      2'd2:    in_ready = avail_s[2];
      2'd3:    in_ready = avail_s[3];
      default: in_ready = 1'b0;
    endcase
  end

  assign load_s = sel_decode(in_sel) & {NUM_CH{in_valid & in_ready}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .width(width)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load_s[g]),
      .data_in (in_data),
      .take    (out_ready[g]),
      .valid   (full_s[g]),
      .data_out(out_data[g*width +: width])
    );
  end

`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt_r [NUM_CH];

  // Per-channel accepted-beat counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_s[i]) cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        else           cnt_r[i] <= cnt_r[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign out_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf. A reference model keeps one queue per
// channel (capacity one) plus accepted-beat counts; DUT outputs are compared
// against it after every clock edge.
module tb_demux4_buf;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef DEMUX4_CNT_EN
  logic [63:0]  out_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: queue per channel, consumed beats seen at DUT outputs.
  logic [31:0] mq  [4][$];
  logic [31:0] got [4][$];
  logic [15:0] mcnt [4];

  demux4_buf #(.width(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
`ifdef DEMUX4_CNT_EN
    .out_cnt  (out_cnt),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int n = 0; n < 4; n++) v[n] = (mq[n].size() > 0);
    return v;
  endfunction

  // Drive one cycle (called at posedge+1), sample in_ready mid-cycle, clock,
  // then advance the model.
  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] ordy,
                       output logic seen_rdy, output logic exp_rdy);
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    #3;
    seen_rdy = in_ready;
    exp_rdy  = (mq[s].size() == 0) || ordy[s];
    if (!r) begin
      for (int n = 0; n < 4; n++)
        if (out_valid[n] && ordy[n]) got[n].push_back(out_data[n*32 +: 32]);
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int n = 0; n < 4; n++) begin
        mq[n].delete(); got[n].delete(); mcnt[n] = 16'd0;
      end
    end else begin
      for (int n = 0; n < 4; n++)
        if (mq[n].size() > 0 && ordy[n]) void'(mq[n].pop_front());
      if (v && exp_rdy) begin
        mq[s].push_back(d);
        mcnt[s] = mcnt[s] + 16'd1;
      end
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
  endtask

  task automatic do_reset();
    logic a, b;
    cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'b0000, a, b);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if (out_data !== 128'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", out_data);
    end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
`ifdef DEMUX4_CNT_EN
    checks++;
    if (out_cnt !== 64'd0) begin
      failures++; $display("FAIL reset_cnt got=%h exp=0", out_cnt);
    end
`endif
  endtask

  task automatic test_routing();
    logic seen, exp;
    do_reset();
    for (int s = 0; s < 4; s++) cycle(1'b0, 1'b1, 2'(s), 32'hA0 + 32'(s), 4'b0000, seen, exp);
    checks++;
    if (out_valid !== 4'b1111) begin
      failures++; $display("FAIL routing_valid got=%b exp=1111", out_valid);
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (out_data[s*32 +: 32] !== 32'hA0 + 32'(s)) begin
        failures++; $display("FAIL routing_data ch=%0d got=%h exp=%h", s, out_data[s*32 +: 32], 32'hA0 + 32'(s));
      end
    end
    cycle(1'b0, 1'b1, 2'd2, 32'hA4, 4'b0000, seen, exp);
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL routing_blocked in_ready got=%b exp=0", seen);
    end
    checks++;
    if (out_data[64 +: 32] !== 32'hA2) begin
      failures++; $display("FAIL routing_hold ch2 got=%h exp=000000a2", out_data[64 +: 32]);
    end
  endtask

  task automatic test_passthrough();
    logic seen, exp;
    do_reset();
    cycle(1'b0, 1'b1, 2'd1, 32'h11, 4'b0000, seen, exp);
    cycle(1'b0, 1'b1, 2'd1, 32'h22, 4'b0010, seen, exp);
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL pass_in_ready got=%b exp=1", seen);
    end
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[32 +: 32] !== 32'h22) begin
      failures++; $display("FAIL pass_reload valid=%b data=%h exp valid=1 data=22", out_valid[1], out_data[32 +: 32]);
    end
    cycle(1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, seen, exp);
    checks++;
    if (got[1].size() != 1 || got[1][0] !== 32'h11) begin
      failures++; $display("FAIL pass_consumed_once count=%0d exp count=1 of 11", got[1].size());
    end
  endtask

  task automatic test_isolation();
    logic seen, exp;
    logic [31:0] beats [8];
    do_reset();
    cycle(1'b0, 1'b1, 2'd3, 32'h33, 4'b0000, seen, exp);
    for (int i = 0; i < 8; i++) begin
      beats[i] = $urandom;
      cycle(1'b0, 1'b1, 2'd0, beats[i], 4'b0001, seen, exp);
      checks++;
      if (seen !== 1'b1) begin
        failures++; $display("FAIL iso_in_ready beat=%0d got=%b exp=1", i, seen);
      end
    end
    cycle(1'b0, 1'b0, 2'd0, 32'd0, 4'b0001, seen, exp);
    checks++;
    if (got[0].size() != 8) begin
      failures++; $display("FAIL iso_count got=%0d exp=8", got[0].size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[0][i] !== beats[i]) begin
          failures++; $display("FAIL iso_order beat=%0d got=%h exp=%h", i, got[0][i], beats[i]);
        end
      end
    end
    checks++;
    if (out_valid[3] !== 1'b1 || out_data[96 +: 32] !== 32'h33) begin
      failures++; $display("FAIL iso_ch3 valid=%b data=%h exp valid=1 data=33", out_valid[3], out_data[96 +: 32]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen, exp;
    do_reset();
    cycle(1'b0, 1'b1, 2'd0, 32'h50, 4'b0000, seen, exp);
    cycle(1'b0, 1'b1, 2'd1, 32'h51, 4'b0000, seen, exp);
    cycle(1'b0, 1'b1, 2'd3, 32'h53, 4'b0000, seen, exp);
    checks++;
    if (out_valid !== 4'b1011) begin
      failures++; $display("FAIL mid_pre_valid got=%b exp=1011", out_valid);
    end
    cycle(1'b1, 1'b1, 2'd2, 32'h52, 4'b0000, seen, exp);
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 128'd0) begin
      failures++; $display("FAIL mid_reset valid=%b data=%h exp valid=0000 data=0", out_valid, out_data);
    end
    cycle(1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, seen, exp);
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL mid_absent valid=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_random();
    logic seen, exp;
    logic [3:0] ev;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)), seen, exp);
      checks++;
      if (seen !== exp) begin
        failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, seen, exp);
      end
      ev = exp_valid();
      checks++;
      if (out_valid !== ev) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, ev);
      end
      for (int n = 0; n < 4; n++) begin
        if (mq[n].size() > 0) begin
          checks++;
          if (out_data[n*32 +: 32] !== mq[n][0]) begin
            failures++; $display("FAIL rand_data cyc=%0d ch=%0d got=%h exp=%h", i, n, out_data[n*32 +: 32], mq[n][0]);
          end
        end
      end
`ifdef DEMUX4_CNT_EN
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (out_cnt[n*16 +: 16] !== mcnt[n]) begin
          failures++; $display("FAIL rand_cnt cyc=%0d ch=%0d got=%0d exp=%0d", i, n, out_cnt[n*16 +: 16], mcnt[n]);
        end
      end
`endif
    end
  endtask

`ifdef DEMUX4_CNT_EN
  task automatic test_cnt_wrap();
    logic seen, exp;
    do_reset();
    for (int i = 0; i < 65537; i++) cycle(1'b0, 1'b1, 2'd2, 32'(i), 4'b0100, seen, exp);
    checks++;
    if (out_cnt[32 +: 16] !== 16'd1) begin
      failures++; $display("FAIL cnt_wrap ch2 got=%0d exp=1", out_cnt[32 +: 16]);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (out_cnt[n*16 +: 16] !== mcnt[n]) begin
        failures++; $display("FAIL cnt_model ch=%0d got=%0d exp=%0d", n, out_cnt[n*16 +: 16], mcnt[n]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'd0; out_ready = 4'b0000;
    for (int n = 0; n < 4; n++) mcnt[n] = 16'd0;
    #1;
    test_reset();
    test_routing();
    test_passthrough();
    test_isolation();
    test_reset_mid();
    test_random();
`ifdef DEMUX4_CNT_EN
    test_cnt_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux4_buf.md
# demux4_buf

Four-way buffered demultiplexer: it steers one valid/ready input stream to one of four output channels selected per beat. Each channel has a one-entry holding register. It is the write-side counterpart to the 4:1 read mux: producers such as the decode stage feed a single port, and independent consumers (functional units, write-back queues) each drain their own channel. Backpressure is per channel, so one stalled consumer blocks only beats addressed to it.

## Interface
- width, 32: data width per beat.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  width  beat payload.
- in_sel  input  2  destination channel, 0..3.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  beat is accepted this cycle when in_valid & in_ready.
- out_data  output  4*width  channel n payload in bits [n*width +: width].
- out_valid  output  4  channel n slot holds a beat.
- out_ready  input  4  consumer n takes its beat this cycle.
- out_cnt  output  4*16  per-channel accepted-beat counters. Present only with DEMUX4_CNT_EN.

## Operation
- Each channel has a slot: a data register plus a full flag. out_valid[n] = full[n]. out_data is driven from the slot register.
- in_ready is combinational: in_ready = ~full[in_sel] | out_ready[in_sel]. It is computed whether or not in_valid is asserted.
- Accept: in_valid & in_ready loads slot[in_sel] with in_data and sets full[in_sel] on the next edge.
- Drain: full[n] & out_ready[n] clears full[n] on the next edge, unless the same cycle also accepts into n.
- Simultaneous drain and accept on the same channel: the slot reloads with the new data and out_valid[n] stays 1. Full throughput is 1 beat/cycle per channel.
- Accept on channel a and drain on channel b≠a in the same cycle: both take effect independently.
- A full slot whose consumer is stalled blocks only beats with in_sel equal to that channel. Beats are never reordered within a channel. Beats are never dropped or duplicated.
- out_ready[n] while full[n]=0 is ignored.
- in_sel, in_data and out_data carry no meaning while their valid is low. The slot data register holds its last value.

## Timing
- Latency: a beat accepted at edge k is visible on out_valid/out_data after edge k, so a consumer can take it in cycle k+1.
- No combinational path from in_data to out_data.
- The only combinational paths are out_ready→in_ready and in_sel→in_ready.
- Reset (rst=1 at a posedge):
  - full = 0, so out_valid = 4'b0000.
  - Data registers = 0, so out_data = 0.
  - out_cnt = 0.
  - in_ready after reset = 1 for any in_sel.
- Reset asserted mid-operation discards all held beats. A handshake in the reset cycle is not recorded.

## Configuration
- DEMUX4_CNT_EN defined:
  - Each channel has a 16-bit counter that increments on every accepted beat to that channel.
  - The counter wraps from 16'hFFFF to 0.
  - out_cnt reflects the count after the accepting edge.
- DEMUX4_CNT_EN undefined: no counters and no out_cnt port. All other behaviour is identical.

## Structure
- Shared package t_utils_pkg: NUM_CH = 4, SEL_W = 2, CNT_W = 16.
- One sub-module, demux_slot:
  - Contains the one-entry holding register and its full flag.
  - Ports: clk, rst, load, data_in, take, valid, data_out. Parameter width.
- The top instantiates four demux_slot. It decodes in_sel into per-slot load, and forms in_ready with a 4:1 select of ~full | out_ready.

## Test plan
- Reset, then check idle outputs: out_valid=0000, out_data=0, in_ready=1, out_cnt=0.
- Routing with stalled consumers:
  - Stimulus: out_ready=0000; send 0xA0 to sel 0, 0xA1 to sel 1, 0xA2 to sel 2, 0xA3 to sel 3 on consecutive cycles.
  - Required: out_valid=1111 and each slot holds its value. A fifth beat to sel 2 sees in_ready=0 and is held off.
- Pass-through on a full channel:
  - Stimulus: channel 1 full with 0x11, out_ready[1]=1, in_valid with 0x22 to sel 1.
  - Required: in_ready=1; the next cycle shows out_valid[1]=1 with 0x22; 0x11 was consumed exactly once.
- Per-channel isolation:
  - Stimulus: channel 3 stalled and full; stream 8 beats to sel 0 with out_ready[0]=1.
  - Required: all 8 beats arrive in order at 1 beat/cycle; channel 3 is unchanged.
- Reset mid-stream:
  - Stimulus: assert rst with out_valid=1011.
  - Required: the next cycle shows out_valid=0000; the beat offered in the reset cycle is absent.
- With DEMUX4_CNT_EN:
  - Stimulus: preload-free run of 65537 beats to sel 2.
  - Required: out_cnt channel 2 = 1; other channels = 0.
